rf_write_arbiter: RTL

- Shares the single write port of the 4x8 register file between NUM_REQ writeback requesters (e.g. ALU, load unit, immediate/move path).
- Uses round-robin priority and a valid/ready handshake per requester.
- Registers the granted write into a one-entry output stage that drives the register file's wen/w_addr/dataIn.
- Forwards the staged, not-yet-committed write onto both read paths, so readers never observe stale data.

---
 rtl/rf_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 57 +++++
 rtl/rf_write_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the 4x8 register file and its write-port sharing logic.
package rf_pkg;

  localparam int REG_ADDR_W = 2;
  localparam int REG_DATA_W = 8;
  localparam int NUM_REGS   = 4;

  // One register-file write: destination register and the value to store.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a one-hot grant. The pointer holds the last granted
// index; the search starts just above it and wraps, so every requester that
// keeps its request up is served within N grants.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] last_grant;
  logic [PW-1:0] gnt_idx;
  logic          found;
  int            best_d;
  int            d;

  // Pick the requester closest (in wrap-around order) after last_grant.
  always_comb begin
    gnt    = '0;
    found  = 1'b0;
    best_d = N;
    d      = 0;
    for (int i = 0; i < N; i++) begin
      d = i - int'(last_grant) - 1;
      if (d < 0) d = d + N;
      if (req[i] && (!found || d < best_d)) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        best_d = d;
        found  = 1'b1;
      end
    end
  end

  // Encode the one-hot grant so it can become the new pointer.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_idx = PW'(i);
    end
  end

  // Pointer moves only when a grant is actually taken; reset favours index 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= PW'(N - 1);
    end else if (advance && (|gnt)) begin
      last_grant <= gnt_idx;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port between NUM_REQ writeback
// sources. The winning write is held one cycle in an output stage that drives
// the register file, and that staged write is forwarded onto both read ports
// until the register file has committed it.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        rf_wen,
  output logic [ADDR_W-1:0]           rf_waddr,
  output logic [DATA_W-1:0]           rf_wdata,
  input  logic [ADDR_W-1:0]           rd_addr1,
  input  logic [ADDR_W-1:0]           rd_addr2,
  input  logic [DATA_W-1:0]           rf_rdata1,
  input  logic [DATA_W-1:0]           rf_rdata2,
  output logic [DATA_W-1:0]           rd_data1,
  output logic [DATA_W-1:0]           rd_data2,
  output logic [NUM_REGS-1:0]         pending_mask
);

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] gnt;
  logic               any_gnt;
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [DATA_W-1:0]  data_arr [NUM_REQ];
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  // Unpack the flat requester buses into per-requester fields.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Stall and reset both mask every request, so no grant (and no pointer move)
  // can happen while either is high.
  assign arb_req   = req_valid & {NUM_REQ{~stall & ~reset}};
  assign req_ready = gnt;
  assign any_gnt   = |gnt;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .advance (any_gnt),
    .gnt     (gnt)
  );

  // Route the granted requester's address and data to the output stage.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = addr_arr[i];
        sel_data = data_arr[i];
      end
    end
  end

  // One-entry output stage: a grant loads it for exactly one cycle; otherwise
  // the enable drops and address/data keep their last values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (any_gnt) begin
      rf_wen   <= 1'b1;
      rf_waddr <= sel_addr;
      rf_wdata <= sel_data;
    end else begin
      rf_wen   <= 1'b0;
    end
  end

  // The staged write is not yet in the register file, so readers of that
  // register get the staged value instead of the stale array contents.
  assign rd_data1 = (rf_wen && (rd_addr1 == rf_waddr)) ? rf_wdata : rf_rdata1;
  assign rd_data2 = (rf_wen && (rd_addr2 == rf_waddr)) ? rf_wdata : rf_rdata2;

  // Decode the staged destination into a per-register pending flag.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pending
    assign pending_mask[gi] = rf_wen && (rf_waddr == ADDR_W'(gi));
  end

endmodule
